// File: rtl/conv_pkg.sv
// Shared widths, FSM state encoding and output-geometry helper for the
// convolution datapath (scheduler, PE and buffers).
package conv_pkg;

  localparam int DATA_W   = 30;
  localparam int WEIGHT_W = 18;
  localparam int ACC_W    = 48;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    FLUSH,
    DONE
  } state_e;

  // Side length of the output map for an F x F input, K x K kernel, stride S.
  function automatic int out_dim(input int f, input int k, input int s);
    return (f - k) / s + 1;
  endfunction

endpackage

// File: rtl/pe_scheduler.sv
// Sequencer for one convolution PE: latches weights, streams the feature map
// row-major with an unbroken enable, and collects results into the output buffer.
module pe_scheduler
  import conv_pkg::*;
#(
  parameter int KERNEL_SIZE = 4,
  parameter int FM_SIZE     = 5,
  parameter int STRIDE      = 1,
  parameter int FM_ADDR_W   = $clog2(FM_SIZE * FM_SIZE),
  parameter int OUT_ADDR_W  =
    (out_dim(FM_SIZE, KERNEL_SIZE, STRIDE) * out_dim(FM_SIZE, KERNEL_SIZE, STRIDE) > 1) ?
    $clog2(out_dim(FM_SIZE, KERNEL_SIZE, STRIDE) * out_dim(FM_SIZE, KERNEL_SIZE, STRIDE)) : 1
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  logic                                         i_start,
  input  logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_W-1:0]  i_weight,
  output logic                                         o_busy,
  output logic                                         o_done,
  output logic                                         o_err,
  output logic                                         o_fm_rd,
  output logic [FM_ADDR_W-1:0]                         o_fm_addr,
  input  logic signed [DATA_W-1:0]                     i_fm_data,
  output logic                                         o_pe_en,
  output logic signed [DATA_W-1:0]                     o_pe_data,
  output logic [KERNEL_SIZE*KERNEL_SIZE*WEIGHT_W-1:0]  o_pe_weight,
  input  logic                                         i_pe_en,
  input  logic signed [ACC_W-1:0]                      i_pe_P,
  output logic                                         o_out_we,
  output logic [OUT_ADDR_W-1:0]                        o_out_addr,
  output logic signed [ACC_W-1:0]                      o_out_data
);

  localparam int W_BITS  = KERNEL_SIZE * KERNEL_SIZE * WEIGHT_W;
  localparam int OUT_DIM = out_dim(FM_SIZE, KERNEL_SIZE, STRIDE);
  localparam int N_PIX   = FM_SIZE * FM_SIZE;
  localparam int N_OUT   = OUT_DIM * OUT_DIM;
  localparam int TMO     = FM_SIZE * KERNEL_SIZE + 8;
  localparam int TMO_W   = $clog2(TMO + 1);
  // One spare bit so the count can reach N_OUT without wrapping to zero.
  localparam int CNT_W   = OUT_ADDR_W + 1;

  state_e                   state_q, state_d;
  logic [FM_ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                     rd_dly_q, rd_dly_d;
  logic [W_BITS-1:0]        weight_q, weight_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [TMO_W-1:0]         flush_cnt_q, flush_cnt_d;
  logic                     err_q, err_d;
  logic                     out_we_q, out_we_d;
  logic [OUT_ADDR_W-1:0]    out_addr_q, out_addr_d;
  logic signed [ACC_W-1:0]  out_data_q, out_data_d;

  logic busy;
  logic capture;

  assign busy = (state_q != IDLE);
  // LOAD is excluded so the count clear never races a stale result strobe.
  assign capture = i_pe_en && busy && (state_q != LOAD) && (cnt_q < CNT_W'(N_OUT));

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    rd_dly_d    = 1'b0;
    weight_d    = weight_q;
    cnt_d       = cnt_q;
    flush_cnt_d = '0;
    err_d       = err_q;
    out_we_d    = 1'b0;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = LOAD;
      end
      LOAD: begin
        weight_d  = i_weight;
        rd_addr_d = '0;
        cnt_d     = '0;
        err_d     = 1'b0;
        state_d   = STREAM;
      end
      STREAM: begin
        rd_dly_d  = 1'b1;
        rd_addr_d = rd_addr_q + FM_ADDR_W'(1);
        if (rd_addr_q == FM_ADDR_W'(N_PIX - 1)) state_d = FLUSH;
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + TMO_W'(1);
        if (cnt_q == CNT_W'(N_OUT)) begin
          state_d = DONE;
        end else if (flush_cnt_q == TMO_W'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      out_we_d   = 1'b1;
      out_addr_d = cnt_q[OUT_ADDR_W-1:0];
      out_data_d = i_pe_P;
      cnt_d      = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      rd_dly_q    <= 1'b0;
      // NOTE: the weight register is reset too, because o_pe_weight must read
      // zero after reset; it is a plain register, not a RAM.
      weight_q    <= '0;
      cnt_q       <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
      out_we_q    <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      rd_dly_q    <= rd_dly_d;
      weight_q    <= weight_d;
      cnt_q       <= cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
      out_we_q    <= out_we_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign o_busy      = busy;
  assign o_done      = (state_q == DONE);
  assign o_err       = err_q;
  assign o_fm_rd     = (state_q == STREAM);
  assign o_fm_addr   = rd_addr_q;
  // Gated by reset so the PE sees its enable drop in the reset cycle itself.
  assign o_pe_en     = i_rst_n && (rd_dly_q || (state_q == FLUSH));
  assign o_pe_data   = rd_dly_q ? i_fm_data : '0;
  assign o_pe_weight = weight_q;
  assign o_out_we    = out_we_q;
  assign o_out_addr  = out_addr_q;
  assign o_out_data  = out_data_q;

endmodule

// File: tb/tb_pe_scheduler.sv
// Bench for pe_scheduler: two configurations (K4/F5/S1 and K3/F5/S2) driven by
// a feature-map buffer model and a behavioural PE model, checked by scoreboard.
module tb_pe_scheduler;

  localparam int F   = 5;
  localparam int KA  = 4;
  localparam int SA  = 1;
  localparam int KB  = 3;
  localparam int SB  = 2;
  localparam int WA  = KA * KA * 18;
  localparam int WB  = KB * KB * 18;
  localparam int TMO = F * KA + 8;

  typedef struct {
    int                 addr;
    logic signed [47:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] req);
    n_checks++;
    assert (obs === req) else begin
      n_fails++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, req);
    end
  endtask

  // Reference window sum; cur is the pixel arriving this cycle at index idx.
  function automatic logic signed [47:0] win_sum(input logic signed [29:0] px[64],
      input logic signed [29:0] cur, input logic [WA-1:0] w, input int k,
      input int s, input int idx, output bit hit);
    int r, c, p;
    logic signed [47:0] acc;
    r   = idx / F;
    c   = idx % F;
    acc = '0;
    hit = (idx < F * F) && (r >= k - 1) && (c >= k - 1) &&
          ((r - k + 1) % s == 0) && ((c - k + 1) % s == 0);
    if (hit)
      for (int kr = 0; kr < k; kr++)
        for (int kc = 0; kc < k; kc++) begin
          p = (r - k + 1 + kr) * F + (c - k + 1 + kc);
          acc += ((p == idx) ? cur : px[p]) * $signed(w[(kr * k + kc) * 18 +: 18]);
        end
    return acc;
  endfunction

  // ---------------- DUT A: K=4, F=5, S=1 ----------------
  logic               rst_n_a, start_a;
  logic [WA-1:0]      w_a, pe_w_a;
  logic               busy_a, done_a, err_a, fm_rd_a, pe_en_a, pv_a, we_a;
  logic [4:0]         fm_addr_a;
  logic signed [29:0] fm_data_a, pe_data_a;
  logic signed [47:0] pp_a, odata_a;
  logic [1:0]         oaddr_a;

  pe_scheduler #(.KERNEL_SIZE(KA), .FM_SIZE(F), .STRIDE(SA)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n_a), .i_start(start_a), .i_weight(w_a),
    .o_busy(busy_a), .o_done(done_a), .o_err(err_a),
    .o_fm_rd(fm_rd_a), .o_fm_addr(fm_addr_a), .i_fm_data(fm_data_a),
    .o_pe_en(pe_en_a), .o_pe_data(pe_data_a), .o_pe_weight(pe_w_a),
    .i_pe_en(pv_a), .i_pe_P(pp_a),
    .o_out_we(we_a), .o_out_addr(oaddr_a), .o_out_data(odata_a)
  );

  // ---------------- DUT B: K=3, F=5, S=2 ----------------
  logic               rst_n_b, start_b;
  logic [WB-1:0]      w_b, pe_w_b;
  logic               busy_b, done_b, err_b, fm_rd_b, pe_en_b, pv_b, we_b;
  logic [4:0]         fm_addr_b;
  logic signed [29:0] fm_data_b, pe_data_b;
  logic signed [47:0] pp_b, odata_b;
  logic [1:0]         oaddr_b;

  pe_scheduler #(.KERNEL_SIZE(KB), .FM_SIZE(F), .STRIDE(SB)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n_b), .i_start(start_b), .i_weight(w_b),
    .o_busy(busy_b), .o_done(done_b), .o_err(err_b),
    .o_fm_rd(fm_rd_b), .o_fm_addr(fm_addr_b), .i_fm_data(fm_data_b),
    .o_pe_en(pe_en_b), .o_pe_data(pe_data_b), .o_pe_weight(pe_w_b),
    .i_pe_en(pv_b), .i_pe_P(pp_b),
    .o_out_we(we_b), .o_out_addr(oaddr_b), .o_out_data(odata_b)
  );

  // Feature-map buffers, read latency 1: A holds all ones, B holds pixel[a] = a.
  always @(posedge clk) if (fm_rd_a) fm_data_a <= 30'sd1;
  always @(posedge clk) if (fm_rd_b) fm_data_b <= 30'(fm_addr_b);

  // PE models: result strobe one cycle after a window's last pixel arrives.
  logic signed [29:0] px_a[64], px_b[64];
  int  idx_a = 0, idx_b = 0;
  bit  hold_a = 0, extra_a = 0;

  always @(posedge clk) begin : pe_model_a
    bit hit;
    logic signed [47:0] v;
    pv_a <= 1'b0;
    if (pe_en_a) begin
      if (idx_a < 64) px_a[idx_a] <= pe_data_a;
      v = win_sum(px_a, pe_data_a, pe_w_a, KA, SA, idx_a, hit);
      if (hit && !hold_a) begin
        pv_a <= 1'b1;
        pp_a <= v;
      end
      idx_a <= idx_a + 1;
    end else begin
      idx_a <= 0;
    end
    if (extra_a && ((pe_en_a && idx_a >= F * F) || !busy_a)) begin
      pv_a <= 1'b1;
      pp_a <= 48'sd999;
    end
  end

  always @(posedge clk) begin : pe_model_b
    bit hit;
    logic signed [47:0] v;
    pv_b <= 1'b0;
    if (pe_en_b) begin
      if (idx_b < 64) px_b[idx_b] <= pe_data_b;
      v = win_sum(px_b, pe_data_b, WA'(pe_w_b), KB, SB, idx_b, hit);
      if (hit) begin
        pv_b <= 1'b1;
        pp_b <= v;
      end
      idx_b <= idx_b + 1;
    end else begin
      idx_b <= 0;
    end
  end

  // Scoreboards and monitors.
  wr_t exp_a[$], exp_b[$];
  int  wr_cnt_a = 0, wr_cnt_b = 0, rdi_a = 0, flush_n_a = 0;
  logic we_hist_a = 1'b0;

  always @(posedge clk) we_hist_a <= we_a;

  always @(negedge clk) begin : mon_a
    wr_t e;
    if (we_a) begin
      wr_cnt_a++;
      check("a_sb_pending", exp_a.size() > 0, 1);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("a_out_addr", oaddr_a, e.addr);
        check("a_out_data", odata_a, e.data);
        check("a_pe_en_held", pe_en_a, 1);
      end
    end
    if (fm_rd_a) begin
      check("a_fm_addr_seq", fm_addr_a, rdi_a);
      rdi_a++;
    end else begin
      rdi_a = 0;
    end
    if (busy_a && pe_en_a && !fm_rd_a) flush_n_a++;
  end

  always @(negedge clk) begin : mon_b
    wr_t e;
    if (we_b) begin
      wr_cnt_b++;
      check("b_sb_pending", exp_b.size() > 0, 1);
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("b_out_addr", oaddr_b, e.addr);
        check("b_out_data", odata_b, e.data);
      end
    end
  end

  task automatic push4_a();
    for (int i = 0; i < 4; i++) exp_a.push_back('{addr: i, data: 48'sd16});
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Wait (bounded) for done on A, then check the end-of-job behaviour.
  task automatic finish_a(input string tag, input bit exp_err, input bit chk_we);
    int n = 0;
    while (!done_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done_a, 1);
    if (done_a) begin
      if (chk_we) check({tag, "_done_after_we"}, we_hist_a, 1);
      check({tag, "_err"}, err_a, exp_err);
      check({tag, "_busy_in_done"}, busy_a, 1);
      @(negedge clk);
      check({tag, "_busy_falls"}, busy_a, 0);
      check({tag, "_done_pulse"}, done_a, 0);
    end
    check({tag, "_sb_drained"}, exp_a.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, n;
    logic [WA-1:0] w_ones;

    w_ones = '0;
    for (int i = 0; i < KA * KA; i++) w_ones[i * 18 +: 18] = 18'd1;
    w_b = '0;
    for (int i = 0; i < KB * KB; i++) w_b[i * 18 +: 18] = 18'd1;
    w_a = w_ones;
    rst_n_a = 1'b0; rst_n_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_a_ctrl", {busy_a, done_a, err_a, fm_rd_a, pe_en_a, we_a}, 0);
    check("rst_a_addr_data", {fm_addr_a, oaddr_a, pe_data_a}, 0);
    check("rst_a_odata", odata_a, 0);
    check("rst_a_weight", pe_w_a === '0, 1);
    check("rst_b_ctrl", {busy_b, done_b, err_b, fm_rd_b, pe_en_b, we_b}, 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    @(negedge clk);

    // Job 1 on A: all pixels and weights one, with start-relative timing.
    push4_a();
    base = wr_cnt_a;
    pulse_start_a();
    check("t1_busy", busy_a, 1);
    check("t1_no_read", fm_rd_a, 0);
    @(negedge clk);
    check("t2_read", fm_rd_a, 1);
    check("t2_addr0", fm_addr_a, 0);
    check("t2_pe_en_low", pe_en_a, 0);
    @(negedge clk);
    check("t3_pe_en", pe_en_a, 1);
    check("t3_pixel0", pe_data_a, 1);
    check("t3_weight", pe_w_a === w_ones, 1);
    finish_a("job1", 0, 1);
    check("job1_writes", wr_cnt_a - base, 4);

    // Start pulsed again mid-STREAM, with different weights on the input.
    push4_a();
    base = wr_cnt_a;
    pulse_start_a();
    repeat (6) @(negedge clk);
    check("mid_streaming", fm_rd_a, 1);
    w_a = {WA{1'b1}};
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("mid_weight_held", pe_w_a === w_ones, 1);
    finish_a("mid", 0, 1);
    check("mid_writes", wr_cnt_a - base, 4);
    w_a = w_ones;

    // Reset during FLUSH after three results.
    push4_a();
    base = wr_cnt_a;
    pulse_start_a();
    n = 0;
    while (wr_cnt_a - base < 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_reached_3", wr_cnt_a - base, 3);
    check("rst_in_flush", {busy_a, fm_rd_a}, 2'b10);
    rst_n_a = 1'b0;
    #1;
    check("rst_pe_en_same_cycle", pe_en_a, 0);
    @(negedge clk);
    check("rst_mid_ctrl", {busy_a, done_a, err_a, fm_rd_a, pe_en_a, we_a}, 0);
    check("rst_mid_addr_data", {fm_addr_a, oaddr_a, pe_data_a}, 0);
    check("rst_mid_odata", odata_a, 0);
    check("rst_mid_weight", pe_w_a === '0, 1);
    check("rst_mid_left", exp_a.size(), 1);
    exp_a.delete();
    rst_n_a = 1'b1;
    @(negedge clk);
    push4_a();
    base = wr_cnt_a;
    pulse_start_a();
    finish_a("post_rst", 0, 1);
    check("post_rst_writes", wr_cnt_a - base, 4);

    // PE withholds results: flush timeout.
    hold_a = 1'b1;
    base = wr_cnt_a;
    flush_n_a = 0;
    pulse_start_a();
    finish_a("tmo", 1, 0);
    check("tmo_flush_cycles", flush_n_a, TMO);
    check("tmo_writes", wr_cnt_a - base, 0);
    repeat (2) @(negedge clk);
    check("tmo_err_sticky", err_a, 1);
    hold_a = 1'b0;
    push4_a();
    base = wr_cnt_a;
    pulse_start_a();
    finish_a("tmo_clear", 0, 1);
    check("tmo_clear_writes", wr_cnt_a - base, 4);

    // Extra result strobes after the last result and while idle.
    extra_a = 1'b1;
    push4_a();
    base = wr_cnt_a;
    pulse_start_a();
    finish_a("extra", 0, 1);
    repeat (5) @(negedge clk);
    extra_a = 1'b0;
    repeat (3) @(negedge clk);
    check("extra_writes", wr_cnt_a - base, 4);

    // B: K=3, S=2, pixel[a] = a -> window sums 54, 72, 144, 162.
    exp_b.push_back('{addr: 0, data: 48'sd54});
    exp_b.push_back('{addr: 1, data: 48'sd72});
    exp_b.push_back('{addr: 2, data: 48'sd144});
    exp_b.push_back('{addr: 3, data: 48'sd162});
    base = wr_cnt_b;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!done_b && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_done_seen", done_b, 1);
    check("b_err", err_b, 0);
    check("b_writes", wr_cnt_b - base, 4);
    check("b_sb_drained", exp_b.size(), 0);
    @(negedge clk);
    check("b_busy_falls", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
